// File: rtl/instr_prefetch_pkg.sv
// Shared constants for the instruction prefetcher and the blocks around it.
//   ADDR_W         : byte-address width of the fetch stream
//   DATA_W         : width of one fetched byte
//   DEFAULT_DEPTH  : default prefetch FIFO entry count (power of two, >= 2)
package instr_prefetch_pkg;
    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 8;
    localparam int DEFAULT_DEPTH = 4;
endpackage

// File: rtl/prefetch_fifo.sv
// Prefetch FIFO holding {addr, data} entries.
// Ports:
//   clk, reset             : clock, asynchronous active-high reset
//   clear                  : synchronous flush (count, head, tail -> 0)
//   push, push_addr/data   : write one entry at the tail
//   pop                    : remove the head entry (ignored when empty)
//   head_addr, head_data   : combinational view of the head entry
//   count, empty           : occupancy
// The caller guarantees a push never finds the FIFO full.
module prefetch_fifo
    import instr_prefetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int DW    = DATA_W,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [AW-1:0] head_addr,
    output logic [DW-1:0] head_data,
    output logic [CW-1:0] count,
    output logic          empty
);
    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    assign empty                  = (count_q == '0);
    assign count                  = count_q;
    assign {head_addr, head_data} = mem_q[head_q];

    always_comb begin
        do_pop  = pop & ~empty;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (do_pop) head_d = head_q + PW'(1);
            if (push)   tail_d = tail_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; contents are only visible when count != 0.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[tail_q] <= {push_addr, push_data};
    end
endmodule

// File: rtl/instr_prefetch.sv
// Instruction byte prefetcher: streams sequential bytes from a 1-cycle
// latency memory into a small FIFO and supports redirects (jumps).
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   memAddr, memStrobe      : read request to memory (memAddr = fetch pc)
//   memDataRead             : read data, valid the cycle after memStrobe
//   byteValid/Data/Addr     : head of the prefetch FIFO
//   byteTake                : consumer pops the head this cycle
//   jumpEn, jumpAddr        : flush and restart fetching at jumpAddr
// Handshake: a byte transfers in any cycle where byteValid and byteTake are
// both high and jumpEn is low; byteTake while byteValid is low is ignored.
module instr_prefetch #(
    parameter int DEPTH  = instr_prefetch_pkg::DEFAULT_DEPTH,
    parameter int ADDR_W = instr_prefetch_pkg::ADDR_W
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic [ADDR_W-1:0]                   memAddr,
    output logic                                memStrobe,
    input  logic [instr_prefetch_pkg::DATA_W-1:0] memDataRead,
    output logic                                byteValid,
    output logic [instr_prefetch_pkg::DATA_W-1:0] byteData,
    output logic [ADDR_W-1:0]                   byteAddr,
    input  logic                                byteTake,
    input  logic                                jumpEn,
    input  logic [ADDR_W-1:0]                   jumpAddr
);
    localparam int DATA_W = instr_prefetch_pkg::DATA_W;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              inflight_q, inflight_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic [CW:0]       occupancy;
    logic              strobe;
    logic              push;
    logic              pop;

    // A slot is reserved for the byte in flight, so a push can never
    // land on a full FIFO.
    assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
    assign strobe    = (occupancy < (CW+1)'(DEPTH)) & ~jumpEn & ~reset;

    // A jump drops the response currently arriving and any pop.
    assign push = inflight_q & ~jumpEn;
    assign pop  = byteTake & ~jumpEn;

    assign memAddr   = fetch_pc_q;
    assign memStrobe = strobe;
    assign byteValid = ~fifo_empty;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        inflight_d = strobe;
        if (jumpEn) begin
            fetch_pc_d = jumpAddr;
        end else if (strobe) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            req_addr_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= '0;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (jumpEn),
        .push      (push),
        .push_addr (req_addr_q),
        .push_data (memDataRead),
        .pop       (pop),
        .head_addr (byteAddr),
        .head_data (byteData),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );
endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;
  logic       clk;
  logic       reset;
  logic [7:0] memAddr;
  logic       memStrobe;
  logic [7:0] memDataRead;
  logic       byteValid;
  logic [7:0] byteData;
  logic [7:0] byteAddr;
  logic       byteTake;
  logic       jumpEn;
  logic [7:0] jumpAddr;

  int checks = 0;
  int errors = 0;

  // memory image and sampled outputs
  logic [7:0]  mem [256];
  logic        s_valid, s_strobe;
  logic [7:0]  s_data, s_addr, s_maddr;

  // reference model: the consumed stream must be mem[a], mem[a+1], ...
  // from the last redirect target; strobes must walk the same addresses.
  logic [15:0] exp_q[$];
  logic [7:0]  q_next;
  logic [7:0]  fetch_exp;
  bit          prev_redirect;
  int          stall;

  instr_prefetch dut (
    .clk         (clk),
    .reset       (reset),
    .memAddr     (memAddr),
    .memStrobe   (memStrobe),
    .memDataRead (memDataRead),
    .byteValid   (byteValid),
    .byteData    (byteData),
    .byteAddr    (byteAddr),
    .byteTake    (byteTake),
    .jumpEn      (jumpEn),
    .jumpAddr    (jumpAddr)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // 1-cycle latency memory
  initial memDataRead = 8'h00;
  always @(posedge clk) begin
    if (memStrobe) memDataRead <= mem[memAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back({q_next, mem[q_next]});
      q_next = q_next + 8'd1;
    end
  endtask

  task automatic redirect(input logic [7:0] a);
    exp_q.delete();
    q_next = a;
    top_up();
  endtask

  task automatic model(input logic rst, input logic take, input logic jmp, input logic [7:0] ja);
    logic [15:0] item;
    if (rst) begin
      chk("rst_valid", byteValid, 0);
      chk("rst_strobe", memStrobe, 0);
      chk("rst_maddr", memAddr, 0);
      fetch_exp = 8'h00;
      redirect(8'h00);
      prev_redirect = 1'b1;
      stall = 0;
    end else begin
      if (prev_redirect) begin
        chk("redir_valid", byteValid, 0);
        chk("redir_strobe", memStrobe, !jmp);
      end
      chk("fetch_addr", memAddr, fetch_exp);
      if (jmp) begin
        chk("jump_strobe", memStrobe, 0);
        fetch_exp = ja;
        redirect(ja);
        prev_redirect = 1'b1;
        stall = 0;
      end else begin
        prev_redirect = 1'b0;
        if (memStrobe) fetch_exp = fetch_exp + 8'd1;
        if (take && byteValid) begin
          item = exp_q.pop_front();
          chk("pop_addr", byteAddr, item[15:8]);
          chk("pop_data", byteData, item[7:0]);
          top_up();
        end
        if (take) stall = 0;
        else stall++;
        if (stall >= 7) begin
          chk("full_valid", byteValid, 1);
          chk("full_strobe", memStrobe, 0);
        end
      end
    end
  endtask

  // driver: apply inputs just after a rising edge, sample mid-cycle
  task automatic cyc(input logic rst, input logic take, input logic jmp, input logic [7:0] ja);
    reset    = rst;
    byteTake = take;
    jumpEn   = jmp;
    jumpAddr = ja;
    #3;
    s_valid  = byteValid;
    s_strobe = memStrobe;
    s_data   = byteData;
    s_addr   = byteAddr;
    s_maddr  = memAddr;
    model(rst, take, jmp, ja);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nstr;
    logic [7:0] wa[3];
    logic [7:0] wd[3];
    logic r, t, j;
    wa = '{8'hFE, 8'hFF, 8'h00};
    wd = '{8'hAA, 8'hBB, 8'h0C};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[0] = 8'h0C; mem[1] = 8'h0A; mem[2] = 8'h1C; mem[3] = 8'h14;
    mem[4] = 8'h02; mem[5] = 8'h01; mem[6] = 8'hFF; mem[7] = 8'h8D;
    mem[8] = 8'h00; mem[9] = 8'h02;
    mem[8'hFE] = 8'hAA; mem[8'hFF] = 8'hBB;

    reset = 1'b1; byteTake = 1'b0; jumpEn = 1'b0; jumpAddr = 8'h00;
    fetch_exp = 8'h00; prev_redirect = 1'b1; stall = 0;
    redirect(8'h00);
    @(posedge clk);
    #1;

    // reset state, then streaming with byteTake held high
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 0, 0);
      if (i < 2) begin
        chk("start_valid", s_valid, 0);
      end else begin
        chk("stream_valid", s_valid, 1);
        chk("stream_addr", s_addr, 32'(i - 2));
      end
      if (i == 0) chk("first_strobe_addr", {s_strobe, s_maddr}, {1'b1, 8'h00});
      if (i == 2) chk("first_byte", s_data, 8'h0C);
    end

    // stall until full, then drain without gap
    cyc(1, 0, 0, 0);
    nstr = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      if (s_strobe) nstr++;
    end
    chk("stall_strobes", nstr, 4);
    chk("held_valid", s_valid, 1);
    chk("held_head", {s_addr, s_data}, {8'h00, 8'h0C});
    chk("held_strobe", s_strobe, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 0);
      chk("drain_valid", s_valid, 1);
      chk("drain_addr", s_addr, 32'(i));
    end

    // jump while half full with a read in flight
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 8'h02);
    chk("hj_valid_before", s_valid, 1);
    cyc(0, 0, 0, 0);
    chk("hj_valid_n1", s_valid, 0);
    chk("hj_strobe_n1", {s_strobe, s_maddr}, {1'b1, 8'h02});
    cyc(0, 0, 0, 0);
    chk("hj_valid_n2", s_valid, 0);
    cyc(0, 0, 0, 0);
    chk("hj_head_n3", {s_valid, s_addr, s_data}, {1'b1, 8'h02, 8'h1C});
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);

    // jump and take together
    cyc(0, 1, 1, 8'h05);
    chk("jt_valid_before", s_valid, 1);
    cyc(0, 1, 0, 0);
    chk("jt_valid_n1", s_valid, 0);
    cyc(0, 1, 0, 0);
    chk("jt_valid_n2", s_valid, 0);
    cyc(0, 1, 0, 0);
    chk("jt_head_n3", {s_valid, s_addr, s_data}, {1'b1, 8'h05, 8'h01});
    cyc(0, 1, 0, 0);

    // address wrap
    cyc(0, 1, 1, 8'hFE);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      chk("wrap_head", {s_valid, s_addr, s_data}, {1'b1, wa[i], wd[i]});
    end

    // reset pulsed mid-stream at fetch pc 5
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
    chk("mr_pc", s_maddr, 8'h04);
    chk("mr_valid_before", s_valid, 1);
    cyc(1, 1, 0, 0);
    chk("mr_valid_drop", s_valid, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      if (i == 0) chk("mr_restart", {s_strobe, s_maddr}, {1'b1, 8'h00});
      if (i == 2) chk("mr_head", {s_valid, s_addr, s_data}, {1'b1, 8'h00, 8'h0C});
    end

    // randomized traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 99) < 1);
      j = ($urandom_range(0, 99) < 4);
      t = ($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 75 : 30));
      cyc(r, t, j, j ? 8'($urandom_range(0, 255)) : 8'h00);
    end
    cyc(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
